// File: rtl/tcam_pipelined.sv
// Ternary CAM with per-entry valid bits, single-cycle flush and a two-stage
// lookup pipeline (match capture, then priority encode + popcount).
module tcam_pipelined #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic             wr_valid,
  input  logic             flush,
  input  logic             lk_req,
  input  logic [WIDTH-1:0] lk_key,
  output logic             lk_done,
  output logic             lk_hit,
  output logic [AW-1:0]    lk_addr,
  output logic             lk_multi,
  output logic [CW-1:0]    lk_count
);

  localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] mask_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] match_now;
  logic [DEPTH-1:0] match_q;
  logic             s1_valid;
  logic [AW-1:0]    enc_addr;
  logic [CW-1:0]    enc_count;

  // Compare against the contents as they stand before this edge's write/flush.
  always_comb begin
    match_now = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_now[i] = valid_q[i] && (((data_q[i] ^ lk_key) & ~mask_q[i]) == '0);
    end
  end

  // Flush overrides a same-cycle write; data and mask survive reset and flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en && ({1'b0, wr_addr} < DEPTH_LIM)) begin
      data_q[wr_addr]  <= wr_data;
      mask_q[wr_addr]  <= wr_mask;
      valid_q[wr_addr] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      match_q  <= '0;
    end else begin
      s1_valid <= lk_req;
      match_q  <= lk_req ? match_now : '0;
    end
  end

  // Descending scan so the lowest matching index is the last one assigned.
  always_comb begin
    enc_addr  = '0;
    enc_count = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_q[i]) begin
        enc_addr = AW'(i);
      end
      enc_count = enc_count + CW'(match_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !s1_valid) begin
      lk_done  <= 1'b0;
      lk_hit   <= 1'b0;
      lk_addr  <= '0;
      lk_multi <= 1'b0;
      lk_count <= '0;
    end else begin
      lk_done  <= 1'b1;
      lk_hit   <= |match_q;
      lk_addr  <= enc_addr;
      lk_multi <= (enc_count >= CW'(2));
      lk_count <= enc_count;
    end
  end

endmodule

// File: doc/tcam_pipelined.md
Name: tcam_pipelined

Overview:
Parametrised ternary CAM with per-entry valid bits, single-cycle flush and a two-stage pipelined lookup. It accepts one lookup per cycle. Each lookup returns the lowest matching index, a hit flag, a multi-hit flag and a match count. It is the successor of the fixed 16x16 TCAM and serves as the lookup engine for classifier/forwarding datapaths.

Parameters:
WIDTH, 16, key/entry data width in bits (>=1)
DEPTH, 16, number of entries (>=2, need not be a power of two)
AW (localparam), clog2(DEPTH), address width
CW (localparam), clog2(DEPTH+1), match-count width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  write entry wr_addr this cycle
wr_addr  in  AW  entry index; values >= DEPTH are ignored (no write)
wr_data  in  WIDTH  stored value
wr_mask  in  WIDTH  stored don't-care mask; bit=1 means the bit is ignored in compare
wr_valid  in  1  valid bit written with the entry (0 = invalidate entry)
flush  in  1  clear all valid bits
lk_req  in  1  lookup request
lk_key  in  WIDTH  lookup key
lk_done  out  1  result valid, exactly one cycle per request
lk_hit  out  1  at least one valid entry matched
lk_addr  out  AW  lowest matching index; 0 when no hit
lk_multi  out  1  two or more entries matched
lk_count  out  CW  number of matching entries

Behaviour:
- Storage: DEPTH x {data[WIDTH], mask[WIDTH], valid}. Storage is in flops, with no read port other than the lookup path.
- Match rule: entry i matches iff valid[i] and ((data[i] ^ key) & ~mask[i]) == 0. Stored data bits under mask=1 never affect the result.
- Write: when wr_en=1 and wr_addr<DEPTH, data, mask and valid are updated at the clock edge and are visible to lookups issued in the next cycle or later.
- Flush: all valid bits are 0 after the edge. Data and mask are unchanged.
- Flush and wr_en in the same cycle: flush wins and the write is dropped entirely.
- Lookup pipeline: fully pipelined, throughput 1 per cycle, no backpressure.
  - Stage 1 (edge after lk_req): the key is compared against the current contents and a DEPTH-bit match vector is registered.
  - Stage 2 (next edge): the match vector is priority-encoded and popcounted into lk_addr, lk_hit, lk_multi and lk_count, and lk_done=1 is registered.
  - Result: lk_req sampled at edge N gives lk_done=1 during cycle N+2.
- Write or flush in the same cycle as lk_req: the lookup sees the pre-write contents. Read-before-write is mandatory.
- Write or flush while lookups are in flight: no effect on match vectors already captured in stage 1.
- When lk_done=0, lk_hit, lk_addr, lk_multi and lk_count are 0.
- When lk_done=1 and there is no match: lk_hit=0, lk_addr=0, lk_multi=0, lk_count=0.
- Priority: the lowest index wins. lk_addr = min{i : match[i]}.
- lk_multi = (lk_count >= 2). lk_count saturates naturally because its maximum is DEPTH.
- Reset (synchronous): all valid bits are 0, both pipeline stages are cleared, all outputs are 0 from the next cycle. Data and mask storage may also be cleared to 0; the bench must not depend on either.
- Reset mid-lookup: in-flight requests are discarded and produce no lk_done.
- lk_req in the same cycle as reset is ignored.
- Entries with wr_valid=0 never match, whatever their mask. An all-ones mask with valid=1 matches every key.

Test Plan:
1. Reset, then a lookup of key 16'h1234 -> lk_done at N+2, with lk_hit=0, lk_addr=0, lk_count=0.
2. Write entry 3 = {16'hAB00, mask 16'h00FF, valid 1} and entry 7 = {16'hABCD, mask 0, valid 1}. Look up 16'hABCD -> lk_hit=1, lk_addr=3, lk_multi=1, lk_count=2. Look up 16'hAB12 -> lk_addr=3, lk_count=1, lk_multi=0.
3. Back-to-back lookups on consecutive cycles with keys 16'hABCD, 16'h0000, 16'hAB55 -> three consecutive lk_done pulses with hit/addr 1/3, 0/0, 1/3.
4. Write entry 5 = 16'h5555 in the same cycle as a lookup of 16'h5555 -> that lookup misses. The same lookup one cycle later -> lk_hit=1, lk_addr=5.
5. With entries 3 and 7 valid, assert flush together with wr_en for entry 2 = 16'hABCD -> a subsequent lookup of 16'hABCD misses and entry 2 stays invalid. Rewrite entry 7 with wr_valid=0 -> no match.
6. Issue lk_req, then assert reset one cycle later -> no lk_done pulse, and all outputs are 0 after reset. Repeat 1–5 with DEPTH=5, WIDTH=8: wr_addr=6 is ignored, and the all-entries-match case gives lk_count=5.
